// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
//   Bundles every signal between control_unit and the ALUSystem datapath.
//   The master modport is the controller side. The slave modport is the
//   datapath side.
//
//   Datapath -> controller:
//     IROut[15:0]     IR contents
//     ALU_Flags[3:0]  {Z,C,N,O}; bit 3 = Z
//
//   Controller -> datapath:
//     RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel
//     ALU_FunSel
//     ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel
//     IR_LH, IR_Enable, IR_FunSel
//     Mem_WR, Mem_CS (Mem_CS is active-low)
//     MuxASel, MuxBSel, MuxCSel
//
//   Status outputs:
//     State     current FSM state, for debug
//     Halted    high in HALT
//     IllegalOp illegal-opcode trap flag
// ---------------------------------------------------------------------------
interface control_unit_if;
  logic [15:0] IROut;
  logic [3:0]  ALU_Flags;

  logic [2:0]  RF_O1Sel;
  logic [2:0]  RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutASel;
  logic [1:0]  ARF_OutBSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_FunSel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [2:0]  State;
  logic        Halted;
  logic        IllegalOp;

  modport master (
    input  IROut, ALU_Flags,
    output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
           ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
           IR_LH, IR_Enable, IR_FunSel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, State, Halted, IllegalOp
  );

  modport slave (
    output IROut, ALU_Flags,
    input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
           ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
           IR_LH, IR_Enable, IR_FunSel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, State, Halted, IllegalOp
  );
endinterface

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Hardwired multi-cycle controller for the ALUSystem datapath.
//   Sequence: fetch the 16-bit instruction in two byte cycles
//   (FETCH_L, FETCH_H), then DECODE, then one or two execute cycles
//   (EXEC1, EXEC2).
//   The control word is a Moore function of the state register and of the
//   instruction latched in DECODE. The one exception is BNE, which also
//   looks at the Z flag during EXEC1.
//
//   Ports:
//     clk  system clock, rising edge active
//     rst  asynchronous, active-high; forces INIT
//     bus  control_unit_if.master; carries IR/flags in and all controls out
//
//   Configuration macro:
//     CU_ILLEGAL_TRAP_EN
//       Defined:   opcodes 0xD/0xE halt the machine and raise IllegalOp
//                  until reset.
//       Undefined: opcodes 0xD/0xE act as NOPs and IllegalOp is tied low.
// ---------------------------------------------------------------------------
module control_unit (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FETCH_L = 3'd1,
    FETCH_H = 3'd2,
    DECODE  = 3'd3,
    EXEC1   = 3'd4,
    EXEC2   = 3'd5,
    HALT    = 3'd7
  } state_t;

  state_t      state;
  logic [15:0] instr;

  // Fields of the latched instruction.
  logic [3:0] op;
  logic       am;
  logic [1:0] rsel;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;

  assign op   = instr[15:12];
  assign am   = instr[10];
  assign rsel = instr[9:8];
  assign dst  = instr[9:8];
  assign src1 = instr[5:4];
  assign src2 = instr[1:0];

  // ADDR and the spare R-type bits go to the datapath, not to the
  // controller. Only Z is consulted among the flags.
  logic unused_bits;
  assign unused_bits = ^{instr[11], instr[7:6], instr[3:2], bus.ALU_Flags[2:0]};

  // RF register code (00 = R1 ... 11 = R4) to one-hot RF_RSel.
  function automatic logic [3:0] rf_onehot(input logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

  function automatic logic is_rtype(input logic [3:0] o);
    return (o >= 4'h4) && (o <= 4'hC);
  endfunction

  // Opcode to ALU function code. 0xC (MOV) falls through to 0000.
  function automatic logic [3:0] alu_code(input logic [3:0] o);
    case (o)
      4'h4:    return 4'b0100;  // ADD
      4'h5:    return 4'b0101;  // SUB
      4'h6:    return 4'b0111;  // AND
      4'h7:    return 4'b1000;  // OR
      4'h8:    return 4'b1010;  // XOR
      4'h9:    return 4'b0010;  // NOT
      4'hA:    return 4'b1011;  // LSL
      4'hB:    return 4'b1100;  // LSR
      default: return 4'b0000;  // MOV
    endcase
  endfunction

  // DECODE looks at IROut directly, because the latch only takes effect
  // on the edge that leaves DECODE.
  function automatic state_t decode_next(input logic [3:0] o);
    case (o)
      4'hF: return HALT;
`ifdef CU_ILLEGAL_TRAP_EN
      4'hD, 4'hE: return HALT;
`else
      4'hD, 4'hE: return FETCH_L;
`endif
      default: return EXEC1;
    endcase
  endfunction

  // LD direct, ST and R-type need a second execute cycle.
  // Everything else returns to fetch.
  function automatic state_t exec1_next(input logic [3:0] o, input logic a);
    if (o == 4'h0)
      return a ? FETCH_L : EXEC2;
    else if (o == 4'h1 || is_rtype(o))
      return EXEC2;
    else
      return FETCH_L;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    state <= FETCH_L;
        FETCH_L: state <= FETCH_H;
        FETCH_H: state <= DECODE;
        DECODE:  state <= decode_next(bus.IROut[15:12]);
        EXEC1:   state <= exec1_next(op, am);
        EXEC2:   state <= FETCH_L;
        HALT:    state <= HALT;
        default: state <= INIT;
      endcase
    end
  end

  // The instruction latch is data, so it has no reset. It is loaded only
  // in DECODE, so later IROut changes cannot disturb EXEC1/EXEC2.
  always_ff @(posedge clk) begin
    if (state == DECODE)
      instr <= bus.IROut;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state == DECODE &&
             (bus.IROut[15:12] == 4'hD || bus.IROut[15:12] == 4'hE))
      illegal_q <= 1'b1;
  end
  assign bus.IllegalOp = illegal_q;
`else
  assign bus.IllegalOp = 1'b0;
`endif

  assign bus.State  = state;
  assign bus.Halted = (state == HALT);

  // ---- control word decode ----
  always_comb begin
    bus.RF_O1Sel    = 3'b000;
    bus.RF_O2Sel    = 3'b000;
    bus.RF_FunSel   = 2'b00;
    bus.RF_RSel     = 4'b0000;
    bus.RF_TSel     = 4'b0000;
    bus.ALU_FunSel  = 4'b0000;
    bus.ARF_OutASel = 2'b00;
    bus.ARF_OutBSel = 2'b00;
    bus.ARF_FunSel  = 2'b00;
    bus.ARF_RSel    = 4'b0000;
    bus.IR_LH       = 1'b0;
    bus.IR_Enable   = 1'b0;
    bus.IR_FunSel   = 2'b00;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = 2'b00;
    bus.MuxBSel     = 2'b00;
    bus.MuxCSel     = 1'b0;

    case (state)
      INIT: begin
        // Clear PC and AR, R1-R4 and T1-T4, and IR.
        bus.ARF_FunSel = 2'b00;
        bus.ARF_RSel   = 4'b1100;
        bus.RF_FunSel  = 2'b00;
        bus.RF_RSel    = 4'b1111;
        bus.RF_TSel    = 4'b1111;
        bus.IR_Enable  = 1'b1;
        bus.IR_FunSel  = 2'b00;
      end

      FETCH_L, FETCH_H: begin
        // Read memory at PC into one IR half, then PC <- PC + 1.
        bus.ARF_OutBSel = 2'b11;
        bus.Mem_CS      = 1'b0;
        bus.IR_Enable   = 1'b1;
        bus.IR_FunSel   = 2'b01;
        bus.IR_LH       = (state == FETCH_H);
        bus.ARF_FunSel  = 2'b10;
        bus.ARF_RSel    = 4'b1000;
      end

      EXEC1: begin
        case (op)
          4'h0: begin
            if (am) begin
              // Immediate: RF <- ADDR through MuxA.
              bus.MuxASel   = 2'b10;
              bus.RF_FunSel = 2'b01;
              bus.RF_RSel   = rf_onehot(rsel);
            end else begin
              bus.MuxBSel    = 2'b10;
              bus.ARF_FunSel = 2'b01;
              bus.ARF_RSel   = 4'b0100;
            end
          end
          4'h1: begin
            bus.MuxBSel    = 2'b10;
            bus.ARF_FunSel = 2'b01;
            bus.ARF_RSel   = 4'b0100;
          end
          4'h2: begin
            bus.MuxBSel    = 2'b10;
            bus.ARF_FunSel = 2'b01;
            bus.ARF_RSel   = 4'b1000;
          end
          4'h3: begin
            // Z here still comes from the previous instruction.
            if (!bus.ALU_Flags[3]) begin
              bus.MuxBSel    = 2'b10;
              bus.ARF_FunSel = 2'b01;
              bus.ARF_RSel   = 4'b1000;
            end
          end
          default: begin
            if (is_rtype(op)) begin
              bus.RF_O1Sel   = {1'b1, src1};
              bus.RF_O2Sel   = {1'b1, src2};
              bus.MuxCSel    = 1'b0;
              bus.ALU_FunSel = alu_code(op);
            end
          end
        endcase
      end

      EXEC2: begin
        case (op)
          4'h0: begin
            // RF <- M[AR].
            bus.ARF_OutBSel = 2'b00;
            bus.Mem_CS      = 1'b0;
            bus.MuxASel     = 2'b01;
            bus.RF_FunSel   = 2'b01;
            bus.RF_RSel     = rf_onehot(rsel);
          end
          4'h1: begin
            // M[AR] <- RF, passed through the ALU.
            bus.RF_O2Sel    = {1'b1, rsel};
            bus.ALU_FunSel  = 4'b0001;
            bus.ARF_OutBSel = 2'b00;
            bus.Mem_CS      = 1'b0;
            bus.Mem_WR      = 1'b1;
          end
          default: begin
            if (is_rtype(op)) begin
              // Hold the operand selects so the ALU result stays valid
              // while it is written back.
              bus.RF_O1Sel   = {1'b1, src1};
              bus.RF_O2Sel   = {1'b1, src2};
              bus.MuxCSel    = 1'b0;
              bus.ALU_FunSel = alu_code(op);
              bus.MuxASel    = 2'b00;
              bus.RF_FunSel  = 2'b01;
              bus.RF_RSel    = rf_onehot(dst);
            end
          end
        endcase
      end

      default: ;  // DECODE and HALT drive the idle word
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Directed testbench for control_unit. The stimulus process drives
//   IROut, ALU_Flags and rst one cycle at a time. For each cycle it queues
//   the complete control word it expects. A monitor pops one entry on every
//   falling edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       halted;
    logic       illegal;
    logic [2:0] o1;
    logic [2:0] o2;
    logic [1:0] rf_fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu;
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] arf_fun;
    logic [3:0] arsel;
    logic       lh;
    logic       en;
    logic [1:0] ir_fun;
    logic       wr;
    logic       cs;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
  } cw_t;

  cw_t   exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  cw_t   mon_act;
  cw_t   mon_exp;
  string mon_tag;

  // ---- monitor ----
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {bus.State, bus.Halted, bus.IllegalOp, bus.RF_O1Sel, bus.RF_O2Sel,
                 bus.RF_FunSel, bus.RF_RSel, bus.RF_TSel, bus.ALU_FunSel,
                 bus.ARF_OutASel, bus.ARF_OutBSel, bus.ARF_FunSel, bus.ARF_RSel,
                 bus.IR_LH, bus.IR_Enable, bus.IR_FunSel, bus.Mem_WR, bus.Mem_CS,
                 bus.MuxASel, bus.MuxBSel, bus.MuxCSel};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                 mon_tag, mon_act, mon_act.st, mon_exp, mon_exp.st);
      end
    end
  end

  // ---- expected control words ----
  function automatic cw_t w_idle(input logic [2:0] st);
    cw_t w;
    w    = '0;
    w.st = st;
    w.cs = 1'b1;
    return w;
  endfunction

  function automatic cw_t w_init();
    cw_t w;
    w         = w_idle(3'd0);
    w.arsel   = 4'b1100;
    w.rsel    = 4'b1111;
    w.tsel    = 4'b1111;
    w.en      = 1'b1;
    return w;
  endfunction

  function automatic cw_t w_fetch(input logic hi);
    cw_t w;
    w         = w_idle(hi ? 3'd2 : 3'd1);
    w.outb    = 2'b11;
    w.cs      = 1'b0;
    w.en      = 1'b1;
    w.ir_fun  = 2'b01;
    w.lh      = hi;
    w.arf_fun = 2'b10;
    w.arsel   = 4'b1000;
    return w;
  endfunction

  function automatic cw_t w_halt(input logic ill);
    cw_t w;
    w         = w_idle(3'd7);
    w.halted  = 1'b1;
    w.illegal = ill;
    return w;
  endfunction

  // Queue the expectation for the current cycle, then advance to just
  // after the next rising edge.
  task automatic cyc(input cw_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ir);
    bus.IROut = ir;
    cyc(w_fetch(1'b0), "fetch_l");
    cyc(w_fetch(1'b1), "fetch_h");
    cyc(w_idle(3'd3), "decode");
  endtask

  cw_t e;

  // ---- stimulus ----
  initial begin
    rst           = 1'b1;
    bus.IROut     = 16'h0000;
    bus.ALU_Flags = 4'b0000;
    @(posedge clk);
    #1;

    cyc(w_init(), "rst_hold");
    rst = 1'b0;
    cyc(w_init(), "rst_release");

    // LD immediate into R2 (AM = 1): 0x0555
    fetch(16'h0555);
    e = w_idle(3'd4); e.ma = 2'b10; e.rf_fun = 2'b01; e.rsel = 4'b0100;
    cyc(e, "ld_imm_exec1");

    // LD direct into R2 (AM = 0): 0x0155
    fetch(16'h0155);
    e = w_idle(3'd4); e.mb = 2'b10; e.arf_fun = 2'b01; e.arsel = 4'b0100;
    cyc(e, "ld_dir_exec1");
    e = w_idle(3'd5); e.cs = 1'b0; e.ma = 2'b01; e.rf_fun = 2'b01; e.rsel = 4'b0100;
    cyc(e, "ld_dir_exec2");

    // ADD R3 <- R2 + R3: 0x4216. IROut is scrambled during EXEC.
    fetch(16'h4216);
    bus.IROut = 16'hF0F0;
    e = w_idle(3'd4); e.o1 = 3'b101; e.o2 = 3'b110; e.alu = 4'b0100;
    cyc(e, "add_exec1");
    e.st = 3'd5; e.rf_fun = 2'b01; e.rsel = 4'b0010;
    cyc(e, "add_exec2");

    // SUB R1 <- R4 - R2: 0x5031
    fetch(16'h5031);
    e = w_idle(3'd4); e.o1 = 3'b111; e.o2 = 3'b101; e.alu = 4'b0101;
    cyc(e, "sub_exec1");
    e.st = 3'd5; e.rf_fun = 2'b01; e.rsel = 4'b1000;
    cyc(e, "sub_exec2");

    // BNE taken (Z = 0): 0x3020
    bus.ALU_Flags = 4'b0000;
    fetch(16'h3020);
    e = w_idle(3'd4); e.mb = 2'b10; e.arf_fun = 2'b01; e.arsel = 4'b1000;
    cyc(e, "bne_taken");

    // BNE not taken (Z = 1)
    bus.ALU_Flags = 4'b1000;
    fetch(16'h3020);
    cyc(w_idle(3'd4), "bne_not_taken");
    bus.ALU_Flags = 4'b0000;

    // BRA: 0x20AA
    fetch(16'h20AA);
    e = w_idle(3'd4); e.mb = 2'b10; e.arf_fun = 2'b01; e.arsel = 4'b1000;
    cyc(e, "bra_exec1");

    // ST from R4: 0x1312
    fetch(16'h1312);
    e = w_idle(3'd4); e.mb = 2'b10; e.arf_fun = 2'b01; e.arsel = 4'b0100;
    cyc(e, "st_exec1");
    e = w_idle(3'd5); e.o2 = 3'b111; e.alu = 4'b0001; e.cs = 1'b0; e.wr = 1'b1;
    cyc(e, "st_exec2");

    // Illegal opcode 0xD
    fetch(16'hD000);
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(w_halt(1'b1), "illegal_trap");
`else
    cyc(w_fetch(1'b0), "illegal_as_nop");
`endif

    // Reset raised between edges takes effect immediately.
    rst = 1'b1;
    cyc(w_init(), "rst_async");
    rst = 1'b0;
    cyc(w_init(), "rst_release2");

    // HLT: stays halted until reset.
    fetch(16'hF000);
    for (int i = 0; i < 12; i++) cyc(w_halt(1'b0), "halt_hold");
    rst = 1'b1;
    cyc(w_init(), "rst_in_halt");
    rst = 1'b0;
    cyc(w_init(), "post_halt_init");
    cyc(w_fetch(1'b0), "restart_fetch");

    #6;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
